// File: rtl/seg_display_ctrl.sv
// Display-register front end: hex pass-through or sequential double-dabble
// binary-to-BCD conversion, with a one-deep pending slot for writes while busy.
module seg_display_ctrl #(
  parameter int          CONV_BITS = 27,
  parameter logic [31:0] ERR_WORD  = 32'hEEEE_EEEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        dec_mode,
  output logic [31:0] disp_out,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  localparam int SH_W  = 32 + CONV_BITS;
  localparam int CNT_W = $clog2(CONV_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_BITS - 1);
  localparam logic [31:0]      DEC_MAX  = 32'd99_999_999;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state_reg, state_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [31:0]       pend_data_reg, pend_data_next;
  logic              pend_dec_reg, pend_dec_next;
  logic [SH_W-1:0]   sh_reg, sh_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       disp_reg, disp_next;
  logic              done_reg, done_next;
  logic              ovf_reg, ovf_next;
  logic              busy_reg, busy_next;

  logic              proc_valid;
  logic [31:0]       proc_data;
  logic              proc_dec;
  logic [31:0]       bcd_adj;

  // Add-3 correction applied to every BCD digit before each shift
  for (genvar gi = 0; gi < 8; gi++) begin : g_adj
    logic [3:0] nib;
    assign nib = sh_reg[CONV_BITS + gi*4 +: 4];
    assign bcd_adj[gi*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  always_comb begin
    state_next      = state_reg;
    pend_valid_next = pend_valid_reg;
    pend_data_next  = pend_data_reg;
    pend_dec_next   = pend_dec_reg;
    sh_next         = sh_reg;
    cnt_next        = cnt_reg;
    disp_next       = disp_reg;
    done_next       = 1'b0;
    ovf_next        = ovf_reg;
    proc_valid      = 1'b0;
    proc_data       = 32'd0;
    proc_dec        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (pend_valid_reg) begin
          // Older pending write goes first; a same-cycle store takes its slot
          proc_valid = 1'b1;
          proc_data  = pend_data_reg;
          proc_dec   = pend_dec_reg;
          if (wr_en) begin
            pend_data_next = wr_data;
            pend_dec_next  = dec_mode;
          end else begin
            pend_valid_next = 1'b0;
          end
        end else if (wr_en) begin
          proc_valid = 1'b1;
          proc_data  = wr_data;
          proc_dec   = dec_mode;
        end
      end
      CONV: begin
        sh_next  = {bcd_adj[30:0], sh_reg[CONV_BITS-1:0], 1'b0};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        disp_next  = sh_reg[SH_W-1 -: 32];
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_reg != IDLE && wr_en) begin
      pend_valid_next = 1'b1;
      pend_data_next  = wr_data;
      pend_dec_next   = dec_mode;
    end

    if (proc_valid) begin
      if (!proc_dec) begin
        disp_next = proc_data;
        done_next = 1'b1;
        ovf_next  = 1'b0;
      end else if (proc_data > DEC_MAX) begin
        disp_next = ERR_WORD;
        done_next = 1'b1;
        ovf_next  = 1'b1;
      end else begin
        sh_next    = {32'd0, proc_data[CONV_BITS-1:0]};
        cnt_next   = '0;
        ovf_next   = 1'b0;
        state_next = CONV;
      end
    end

    busy_next = (state_next != IDLE) || pend_valid_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= 32'd0;
      pend_dec_reg   <= 1'b0;
      sh_reg         <= '0;
      cnt_reg        <= '0;
      disp_reg       <= 32'd0;
      done_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_valid_next;
      pend_data_reg  <= pend_data_next;
      pend_dec_reg   <= pend_dec_next;
      sh_reg         <= sh_next;
      cnt_reg        <= cnt_next;
      disp_reg       <= disp_next;
      done_reg       <= done_next;
      ovf_reg        <= ovf_next;
      busy_reg       <= busy_next;
    end
  end

  assign disp_out = disp_reg;
  assign done     = done_reg;
  assign ovf      = ovf_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: hex, decimal, range limits,
// pending-slot behaviour and asynchronous reset during conversion.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        dec_mode;
  logic [31:0] disp_out;
  logic        busy;
  logic        done;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  seg_display_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .dec_mode (dec_mode),
    .disp_out (disp_out),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Store sampled at the next rising edge; returns 1ns after that edge
  task automatic do_write(input logic [31:0] data, input logic dec);
    wr_en    = 1'b1;
    wr_data  = data;
    dec_mode = dec;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    wr_data  = 32'd0;
    dec_mode = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int done_seen;
    rst      = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 32'd0;
    dec_mode = 1'b0;
    cycles(3);
    chk("rst_disp", disp_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycles(1);

    // Hex pass-through, one-cycle done
    do_write(32'h1234_ABCD, 1'b0);
    chk("hex_disp", disp_out, 32'h1234_ABCD);
    chk("hex_done", {31'd0, done}, 32'd1);
    chk("hex_busy", {31'd0, busy}, 32'd0);
    chk("hex_ovf",  {31'd0, ovf},  32'd0);
    cycles(1);
    chk("hex_done_off", {31'd0, done}, 32'd0);

    // Decimal 12_345_678: result lands exactly at T+28
    do_write(32'd12_345_678, 1'b1);
    chk("dec_busy", {31'd0, busy}, 32'd1);
    chk("dec_done0", {31'd0, done}, 32'd0);
    cycles(27);
    chk("dec_t27_disp", disp_out, 32'h1234_ABCD);
    chk("dec_t27_done", {31'd0, done}, 32'd0);
    cycles(1);
    chk("dec_disp", disp_out, 32'h1234_5678);
    chk("dec_done", {31'd0, done}, 32'd1);
    chk("dec_busy_off", {31'd0, busy}, 32'd0);
    cycles(1);

    // Range limits
    do_write(32'd0, 1'b1);
    cycles(28);
    chk("zero_disp", disp_out, 32'h0000_0000);
    chk("zero_done", {31'd0, done}, 32'd1);
    cycles(1);
    do_write(32'd99_999_999, 1'b1);
    cycles(28);
    chk("max_disp", disp_out, 32'h9999_9999);
    chk("max_done", {31'd0, done}, 32'd1);
    cycles(1);
    do_write(32'd100_000_000, 1'b1);
    chk("ovf_disp", disp_out, 32'hEEEE_EEEE);
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    chk("ovf_done", {31'd0, done}, 32'd1);
    chk("ovf_busy", {31'd0, busy}, 32'd0);
    cycles(1);
    do_write(32'h0000_0055, 1'b0);
    chk("ovf_clear", {31'd0, ovf}, 32'd0);
    chk("ovf_clr_disp", disp_out, 32'h0000_0055);
    cycles(1);

    // Writes while busy: 0xA superseded by 0xB
    do_write(32'd5, 1'b1);            // T
    cycles(2);
    do_write(32'h0000_000A, 1'b0);    // T+3
    cycles(1);
    do_write(32'h0000_000B, 1'b0);    // T+5
    chk("pend_busy", {31'd0, busy}, 32'd1);
    cycles(22);                       // T+27
    chk("pend_t27", disp_out, 32'h0000_0055);
    cycles(1);                        // T+28
    chk("pend_dec5", disp_out, 32'h0000_0005);
    chk("pend_busy28", {31'd0, busy}, 32'd1);
    cycles(1);                        // T+29
    chk("pend_hexB", disp_out, 32'h0000_000B);
    chk("pend_doneB", {31'd0, done}, 32'd1);
    chk("pend_idle", {31'd0, busy}, 32'd0);
    cycles(1);

    // Pending consumed while a new decimal store arrives
    do_write(32'd7, 1'b1);            // T
    cycles(1);
    do_write(32'h0000_000B, 1'b0);    // T+2, pending
    cycles(26);                       // T+28
    chk("pn_dec7", disp_out, 32'h0000_0007);
    do_write(32'd42, 1'b1);           // T+29: 0xB shown, 42 pending
    chk("pn_hexB", disp_out, 32'h0000_000B);
    chk("pn_busy", {31'd0, busy}, 32'd1);
    cycles(1);                        // T' : 42 loaded
    chk("pn_done_off", {31'd0, done}, 32'd0);
    chk("pn_conv_busy", {31'd0, busy}, 32'd1);
    cycles(27);
    chk("pn_t27", disp_out, 32'h0000_000B);
    cycles(1);
    chk("pn_dec42", disp_out, 32'h0000_0042);
    chk("pn_done42", {31'd0, done}, 32'd1);
    chk("pn_busy_off", {31'd0, busy}, 32'd0);
    cycles(1);

    // Asynchronous reset mid-conversion
    do_write(32'd77, 1'b1);
    cycles(9);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_disp", disp_out, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_ovf",  {31'd0, ovf},  32'd0);
    cycles(2);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      if (done === 1'b1 || disp_out !== 32'd0) done_seen++;
    end
    chk("ar_no_done", done_seen, 32'd0);
    do_write(32'h00C0_FFEE, 1'b0);
    chk("ar_hex_disp", disp_out, 32'h00C0_FFEE);
    chk("ar_hex_done", {31'd0, done}, 32'd1);
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
